merge14: RTL and testbench

Two-to-one upward merge node for the tree NoC: the reverse-direction counterpart of the routing decoder. It accepts 9-bit packets from two child channels (In0, In1), arbitrates round-robin, reports the winning child on a 1-bit side channel S, then forwards the packet unchanged on Out toward the parent. It sits at every internal tree node, paired with the decoder that drives traffic downward.

---
 rtl/noc_pkg.sv | 16 +
 rtl/rr_arb2.sv | 32 +++
 rtl/merge14.sv | 109 ++++++++++
 tb/tb_merge14.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the tree NoC: packet layout and merge-node FSM states.
package noc_pkg;

  localparam int W       = 9;
  localparam int ADDR_HI = 8;
  localparam int ADDR_LO = 5;

  typedef logic [W-1:0] packet_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND_S,
    SEND_OUT
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the input that wins a tie and
// moves to the loser of every grant, so two continuously requesting inputs alternate.
module rr_arb2 (
  input  logic       CLK,
  input  logic       _RESET,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_idx
);

  logic prio;

  // Winner: the pointer on a tie, otherwise whichever input is requesting.
  always_comb begin
    // NOTE: default assignment first so no path leaves gnt_idx unassigned (no latch).
    gnt_idx = 1'b0;
    if (req == 2'b11)
      gnt_idx = prio;
    else if (req[1])
      gnt_idx = 1'b1;
  end

  // Pointer update: after each grant the other input gets the next tie.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!_RESET)
      prio <= 1'b0;
    else if (grant_en && (req != 2'b00))
      prio <= ~gnt_idx;
  end

endmodule

// File: rtl/merge14.sv
// Two-to-one upward merge node. Each child channel feeds a one-entry holding
// register; a round-robin grant picks a full hold, the source index is sent on S
// and only after S is accepted is the untouched packet presented on Out.
module merge14
  import noc_pkg::*;
(
  input  logic    CLK,
  input  logic    _RESET,
  input  packet_t In0_data,
  input  logic    In0_valid,
  output logic    In0_ready,
  input  packet_t In1_data,
  input  logic    In1_valid,
  output logic    In1_ready,
  output logic    S_data,
  output logic    S_valid,
  input  logic    S_ready,
  output packet_t Out_data,
  output logic    Out_valid,
  input  logic    Out_ready
);

  state_t  state;
  packet_t hold0, hold1;
  packet_t out_reg;
  logic    full0, full1;
  logic    sel;
  logic    grant;
  logic    gnt_idx;
  logic    take0, take1;

  // Ready comes straight from the registered full flags.
  assign In0_ready = !full0;
  assign In1_ready = !full1;
  assign take0     = In0_valid && In0_ready;
  assign take1     = In1_valid && In1_ready;
  assign grant     = (state == IDLE) && (full0 || full1);
  assign S_data    = sel;
  assign Out_data  = out_reg;

  rr_arb2 u_arb (
    .CLK      (CLK),
    ._RESET   (_RESET),
    .req      ({full1, full0}),
    .grant_en (grant),
    .gnt_idx  (gnt_idx)
  );

  // Hold data capture; contents are only meaningful while the full flag is set.
  always_ff @(posedge CLK) begin
    // NOTE: data-only registers are left unreset; the full flags qualify them.
    if (take0) hold0 <= In0_data;
    if (take1) hold1 <= In1_data;
  end

  // Full flags: cleared by a grant in IDLE, set by an input transfer.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
    end else begin
      if (grant && !gnt_idx)     full0 <= 1'b0;
      else if (take0)            full0 <= 1'b1;
      if (grant && gnt_idx)      full1 <= 1'b0;
      else if (take1)            full1 <= 1'b1;
    end
  end

  // Sequencing FSM: grant, then source on S, then packet on Out.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      state     <= IDLE;
      sel       <= 1'b0;
      out_reg   <= '0;
      S_valid   <= 1'b0;
      Out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            sel     <= gnt_idx;
            out_reg <= gnt_idx ? hold1 : hold0;
            S_valid <= 1'b1;
            state   <= SEND_S;
          end
        end
        SEND_S: begin
          if (S_ready) begin
            S_valid   <= 1'b0;
            Out_valid <= 1'b1;
            state     <= SEND_OUT;
          end
        end
        SEND_OUT: begin
          if (Out_ready) begin
            Out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          S_valid   <= 1'b0;
          Out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merge14.sv
// Bench for merge14: table of single-packet vectors, hand-written backpressure and
// reset sequences, and a queue scoreboard for contention, fairness and integrity.
module tb_merge14;
  import noc_pkg::*;

  logic    CLK = 1'b0;
  logic    _RESET;
  packet_t In0_data, In1_data, Out_data;
  logic    In0_valid, In0_ready, In1_valid, In1_ready;
  logic    S_data, S_valid, S_ready;
  logic    Out_valid, Out_ready;

  merge14 dut (
    .CLK       (CLK),
    ._RESET    (_RESET),
    .In0_data  (In0_data),
    .In0_valid (In0_valid),
    .In0_ready (In0_ready),
    .In1_data  (In1_data),
    .In1_valid (In1_valid),
    .In1_ready (In1_ready),
    .S_data    (S_data),
    .S_valid   (S_valid),
    .S_ready   (S_ready),
    .Out_data  (Out_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    _RESET    = 1'b0;
    In0_valid = 1'b0;
    In1_valid = 1'b0;
    In0_data  = '0;
    In1_data  = '0;
    S_ready   = 1'b1;
    Out_ready = 1'b1;
    tick();
    tick();
    _RESET = 1'b1;
  endtask

  // ---------------- scoreboard-driven streaming ----------------
  packet_t q0[$], q1[$];
  packet_t out_hist[$];
  bit      s_seq[$];
  bit      last_src;
  int      rem0, rem1, sent0, sent1, out_count;
  bit      stall_mode;

  function automatic packet_t gen(input bit src, input int idx);
    if (src) return packet_t'((idx * 37 + 5) % 512);
    return packet_t'(idx % 512);
  endfunction

  task automatic start_stream(input packet_t p0, input packet_t p1, input int n0, input int n1);
    q0.delete(); q1.delete(); out_hist.delete(); s_seq.delete();
    out_count = 0; sent0 = 0; sent1 = 0;
    rem0 = n0; rem1 = n1;
    In0_data = p0; In1_data = p1;
    In0_valid = (n0 > 0);
    In1_valid = (n1 > 0);
  endtask

  task automatic step();
    bit t0, t1, ts, to;
    bit s_v;
    packet_t o_v;
    t0  = In0_valid && In0_ready;
    t1  = In1_valid && In1_ready;
    ts  = S_valid && S_ready;
    to  = Out_valid && Out_ready;
    s_v = S_data;
    o_v = Out_data;
    if (t0) q0.push_back(In0_data);
    if (t1) q1.push_back(In1_data);
    tick();
    if (ts) begin
      s_seq.push_back(s_v);
      last_src = s_v;
    end
    if (to) begin
      out_hist.push_back(o_v);
      out_count++;
      if (last_src == 1'b0 && q0.size() > 0)      check("out_data_in0", o_v, q0.pop_front());
      else if (last_src == 1'b1 && q1.size() > 0) check("out_data_in1", o_v, q1.pop_front());
      else                                        check("out_unexpected", 1, 0);
    end
    if (t0) begin
      sent0++; rem0--;
      if (rem0 > 0) In0_data = gen(1'b0, sent0);
      else          In0_valid = 1'b0;
    end
    if (t1) begin
      sent1++; rem1--;
      if (rem1 > 0) In1_data = gen(1'b1, sent1);
      else          In1_valid = 1'b0;
    end
    if (stall_mode) begin
      S_ready   = ($urandom_range(0, 3) != 0);
      Out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      S_ready   = 1'b1;
      Out_ready = 1'b1;
    end
  endtask

  task automatic run_until(input string name, input int target, input int budget);
    int cyc = 0;
    while (out_count < target && cyc < budget) begin
      step();
      cyc++;
    end
    check(name, out_count, target);
  endtask

  // ---------------- single-packet vector table ----------------
  typedef struct {
    bit      src;
    packet_t data;
    bit      exp_s;
    packet_t exp_out;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 9'h1A5, 1'b0, 9'h1A5};
    vecs[1] = '{1'b1, 9'h0FF, 1'b1, 9'h0FF};
    vecs[2] = '{1'b0, 9'h000, 1'b0, 9'h000};
    vecs[3] = '{1'b1, 9'h1FF, 1'b1, 9'h1FF};
    vecs[4] = '{1'b0, 9'h155, 1'b0, 9'h155};

    do_reset();
    check("rst_in0_ready", In0_ready, 1);
    check("rst_in1_ready", In1_ready, 1);
    check("rst_s_valid",   S_valid,   0);
    check("rst_s_data",    S_data,    0);
    check("rst_out_valid", Out_valid, 0);
    check("rst_out_data",  Out_data,  0);

    // Single packets: capture, grant, S transfer, then Out three edges after capture.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].src) begin In1_valid = 1'b1; In1_data = vecs[i].data; end
      else             begin In0_valid = 1'b1; In0_data = vecs[i].data; end
      tick();
      In0_valid = 1'b0;
      In1_valid = 1'b0;
      check("v_hold_busy", vecs[i].src ? In1_ready : In0_ready, 0);
      check("v_s_valid_e1", S_valid, 0);
      check("v_out_valid_e1", Out_valid, 0);
      tick();
      check("v_s_valid_e2", S_valid, 1);
      check("v_s_data", S_data, vecs[i].exp_s);
      check("v_out_valid_e2", Out_valid, 0);
      tick();
      check("v_out_valid_e3", Out_valid, 1);
      check("v_out_data", Out_data, vecs[i].exp_out);
      check("v_s_valid_e3", S_valid, 0);
      tick();
      check("v_out_valid_e4", Out_valid, 0);
    end

    // Simultaneous arrival after reset: In0 first.
    do_reset();
    stall_mode = 1'b0;
    start_stream(9'h011, 9'h122, 1, 1);
    run_until("simul_drain", 2, 40);
    if (s_seq.size() >= 2 && out_hist.size() >= 2) begin
      check("simul_s0", s_seq[0], 0);
      check("simul_s1", s_seq[1], 1);
      check("simul_out0", out_hist[0], 9'h011);
      check("simul_out1", out_hist[1], 9'h122);
    end else check("simul_count", s_seq.size(), 2);

    // Fairness: both inputs streaming, grants alternate.
    do_reset();
    start_stream(gen(1'b0, 0), gen(1'b1, 0), 8, 8);
    run_until("fair_drain", 16, 200);
    for (int i = 0; i < 8; i++)
      if (i < s_seq.size()) check("fair_s", s_seq[i], i % 2);
      else                  check("fair_s_missing", i, s_seq.size());

    // Backpressure on S, then on Out.
    do_reset();
    S_ready   = 1'b0;
    In0_valid = 1'b1; In0_data = 9'h0AA;
    tick();
    In0_data  = 9'h0BB;
    In1_valid = 1'b1; In1_data = 9'h1CC;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_s_valid", S_valid, 1);
      check("bp_s_data", S_data, 0);
      check("bp_out_valid", Out_valid, 0);
      tick();
    end
    check("bp_in0_ready", In0_ready, 0);
    check("bp_in1_ready", In1_ready, 0);
    In0_valid = 1'b0;
    In1_valid = 1'b0;
    S_ready   = 1'b1;
    Out_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("bp_out_hold_valid", Out_valid, 1);
      check("bp_out_hold_data", Out_data, 9'h0AA);
      check("bp_out_s_valid", S_valid, 0);
      tick();
    end
    Out_ready = 1'b1;
    In1_valid = 1'b1; In1_data = 9'h1DD;
    tick();
    tick();
    check("bp_second_s_valid", S_valid, 1);
    check("bp_second_s_data", S_data, 1);
    Out_ready = 1'b0;
    tick();
    In1_valid = 1'b0;
    check("mid_out_data", Out_data, 9'h1CC);
    check("mid_in0_full", In0_ready, 0);
    check("mid_in1_full", In1_ready, 0);

    // Reset in SEND_OUT with both holds full.
    _RESET = 1'b0;
    tick();
    check("mrst_out_valid", Out_valid, 0);
    check("mrst_s_valid", S_valid, 0);
    check("mrst_in0_ready", In0_ready, 1);
    check("mrst_in1_ready", In1_ready, 1);
    check("mrst_out_data", Out_data, 0);
    _RESET = 1'b1;
    start_stream(9'h055, 9'h166, 1, 1);
    run_until("mrst_drain", 2, 40);
    if (s_seq.size() >= 1) check("mrst_first_grant", s_seq[0], 0);
    else                   check("mrst_no_grant", s_seq.size(), 1);

    // Data integrity: all 512 values on both inputs with random stalls.
    do_reset();
    stall_mode = 1'b1;
    start_stream(gen(1'b0, 0), gen(1'b1, 0), 512, 512);
    run_until("int_drain", 1024, 20000);
    check("int_q0_empty", q0.size(), 0);
    check("int_q1_empty", q1.size(), 0);
    check("int_sent0", sent0, 512);
    check("int_sent1", sent1, 512);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
